// File: rtl/mul_div_pkg.sv
// Shared definitions for the mul_div HI/LO unit: operation codes, FSM states
// and the log helper used to size the iteration counter.
package mul_div_pkg;

  localparam int unsigned MD_CTRL_WIDTH = 3;

  typedef enum logic [MD_CTRL_WIDTH-1:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_SIGN = 2'd2,
    ST_DONE = 2'd3
  } md_state_e;

  // Ceiling log2, evaluated at elaboration time.
  function automatic int unsigned md_log2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mul_div_iter.sv
// One combinational iteration of the multi-cycle unit: a shift-add multiply
// step or a restoring shift-subtract divide step, selected by mode_i.
module md_iter
  import mul_div_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  mode_i,     // 0: multiply, 1: divide
  input  logic [DATA_WIDTH-1:0] hi_i,       // product high half / remainder
  input  logic [DATA_WIDTH-1:0] lo_i,       // multiplier bits / dividend-quotient
  input  logic [DATA_WIDTH-1:0] operand_i,  // multiplicand / divisor
  output logic [DATA_WIDTH-1:0] hi_o,
  output logic [DATA_WIDTH-1:0] lo_o
);

  logic [DATA_WIDTH:0] sum;
  logic [DATA_WIDTH:0] shifted;
  logic [DATA_WIDTH:0] diff;

  always_comb begin
    sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, operand_i} : '0);
    shifted = {hi_i, lo_i[DATA_WIDTH-1]};
    diff    = shifted - {1'b0, operand_i};
    hi_o    = '0;
    lo_o    = '0;
    if (!mode_i) begin
      hi_o = sum[DATA_WIDTH:1];
      lo_o = {sum[0], lo_i[DATA_WIDTH-1:1]};
    end else begin
      // Partial remainder never exceeds the divisor, so W bits hold it
      // whichever branch is taken.
      hi_o = diff[DATA_WIDTH] ? shifted[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
      lo_o = {lo_i[DATA_WIDTH-2:0], ~diff[DATA_WIDTH]};
    end
  end

endmodule

// File: rtl/mul_div.sv
// Multi-cycle MIPS multiply/divide unit with architectural HI/LO registers.
// Define MUL_DIV_FAST_MUL_EN for single-cycle MULT/MULTU.
module mul_div
  import mul_div_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [MD_CTRL_WIDTH-1:0] i_operation,
  input  logic [DATA_WIDTH-1:0]    i_data_a,
  input  logic [DATA_WIDTH-1:0]    i_data_b,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [DATA_WIDTH-1:0]    o_hi,
  output logic [DATA_WIDTH-1:0]    o_lo
);

  localparam int unsigned CNT_W = md_log2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_WIDTH - 1);

  md_state_e             state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  div_q;
  logic                  neg_q;
  logic                  neg_rem_q;
  logic                  dzero_q;
  logic [DATA_WIDTH-1:0] a_raw_q;
  logic [DATA_WIDTH-1:0] opnd_q;
  logic [DATA_WIDTH-1:0] acc_hi_q;
  logic [DATA_WIDTH-1:0] acc_lo_q;
  logic [DATA_WIDTH-1:0] hi_q;
  logic [DATA_WIDTH-1:0] lo_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  can_accept;
  logic                  is_mul;
  logic                  is_div;
  logic                  is_signed;
  logic                  a_neg;
  logic                  b_neg;
  logic [DATA_WIDTH-1:0] a_mag;
  logic [DATA_WIDTH-1:0] b_mag;
  logic                  launch;
  logic [DATA_WIDTH-1:0] iter_hi;
  logic [DATA_WIDTH-1:0] iter_lo;
  logic [2*DATA_WIDTH-1:0] prod_fix;
  logic [DATA_WIDTH-1:0] fix_hi_d;
  logic [DATA_WIDTH-1:0] fix_lo_d;

  md_iter #(.DATA_WIDTH(DATA_WIDTH)) u_iter (
    .mode_i    (div_q),
    .hi_i      (acc_hi_q),
    .lo_i      (acc_lo_q),
    .operand_i (opnd_q),
    .hi_o      (iter_hi),
    .lo_o      (iter_lo)
  );

  always_comb begin
    can_accept = (state_q == ST_IDLE) || (state_q == ST_DONE);
    is_mul     = (i_operation == MD_MULT) || (i_operation == MD_MULTU);
    is_div     = (i_operation == MD_DIV)  || (i_operation == MD_DIVU);
    is_signed  = (i_operation == MD_MULT) || (i_operation == MD_DIV);
    a_neg      = is_signed && i_data_a[DATA_WIDTH-1];
    b_neg      = is_signed && i_data_b[DATA_WIDTH-1];
    a_mag      = a_neg ? ('0 - i_data_a) : i_data_a;
    b_mag      = b_neg ? ('0 - i_data_b) : i_data_b;
`ifdef MUL_DIV_FAST_MUL_EN
    launch     = i_start && can_accept && is_div;
`else
    launch     = i_start && can_accept && (is_div || is_mul);
`endif
  end

`ifdef MUL_DIV_FAST_MUL_EN
  logic [2*DATA_WIDTH-1:0] fast_a;
  logic [2*DATA_WIDTH-1:0] fast_b;
  logic [2*DATA_WIDTH-1:0] fast_prod;

  // Sign-extending to 2W makes the truncated unsigned product equal the
  // signed product, so one multiplier serves MULT and MULTU.
  always_comb begin
    fast_a    = {{DATA_WIDTH{is_signed && i_data_a[DATA_WIDTH-1]}}, i_data_a};
    fast_b    = {{DATA_WIDTH{is_signed && i_data_b[DATA_WIDTH-1]}}, i_data_b};
    fast_prod = fast_a * fast_b;
  end
`endif

  always_comb begin
    prod_fix = {acc_hi_q, acc_lo_q};
    if (neg_q) prod_fix = '0 - prod_fix;
    fix_hi_d = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
    fix_lo_d = prod_fix[DATA_WIDTH-1:0];
    if (div_q) begin
      fix_lo_d = neg_q     ? ('0 - acc_lo_q) : acc_lo_q;
      fix_hi_d = neg_rem_q ? ('0 - acc_hi_q) : acc_hi_q;
      if (dzero_q) begin
        fix_lo_d = '1;
        fix_hi_d = a_raw_q;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dzero_q   <= 1'b0;
      a_raw_q   <= '0;
      opnd_q    <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          if (i_start) begin
            case (i_operation)
              MD_MTHI: hi_q <= i_data_a;
              MD_MTLO: lo_q <= i_data_a;
`ifdef MUL_DIV_FAST_MUL_EN
              MD_MULT, MD_MULTU: begin
                hi_q   <= fast_prod[2*DATA_WIDTH-1:DATA_WIDTH];
                lo_q   <= fast_prod[DATA_WIDTH-1:0];
                done_q <= 1'b1;
              end
`endif
              default: ;
            endcase
          end
          if (launch) begin
            state_q   <= ST_CALC;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            div_q     <= is_div;
            neg_q     <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            dzero_q   <= is_div && (i_data_b == '0);
            a_raw_q   <= i_data_a;
            acc_hi_q  <= '0;
            acc_lo_q  <= is_div ? a_mag : b_mag;
            opnd_q    <= is_div ? b_mag : a_mag;
          end
        end
        ST_CALC: begin
          acc_hi_q <= iter_hi;
          acc_lo_q <= iter_lo;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) state_q <= ST_SIGN;
        end
        ST_SIGN: begin
          hi_q    <= fix_hi_d;
          lo_q    <= fix_lo_d;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= ST_DONE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_hi   = hi_q;
  assign o_lo   = lo_q;

endmodule
